debug_overlay: RTL and testbench



---
 rtl/debug_overlay_if.sv | 18 +
 rtl/debug_overlay.sv | 134 +++++++++++++
 tb/tb_debug_overlay.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/debug_overlay_if.sv
// debug_overlay_if: video, control and text-buffer signals of the debug overlay.
interface debug_overlay_if #(
   parameter int NLINES = 2,
   parameter int NCHARS = 32
);
   logic [9:0]                  hcount;
   logic [9:0]                  vcount;
   logic                        vblank;
   logic                        ena;
   logic [NLINES*NCHARS*5-1:0]  line_data;
   logic [7:0]                  in_r, in_g, in_b;
   logic [7:0]                  out_r, out_g, out_b;
   logic                        active;
   modport master (output hcount, vcount, vblank, ena, line_data, in_r, in_g, in_b,
                   input out_r, out_g, out_b, active);
   modport slave (input hcount, vcount, vblank, ena, line_data, in_r, in_g, in_b,
                  output out_r, out_g, out_b, active);
endinterface

// File: rtl/debug_overlay.sv
// debug_overlay: 3-stage text overlay of NLINES x NCHARS 8x8 cells mixed into RGB video.
// Define OVERLAY_SHADOW_EN to latch line_data once per frame on vblank rise.
module debug_overlay #(
   parameter int NLINES     = 2,
   parameter int NCHARS     = 32,
   parameter int X0         = 16,
   parameter int Y0         = 8,
   parameter int SCALE_LOG2 = 0
) (
   input  logic            clk_sys,
   input  logic            reset,
   debug_overlay_if.slave  bus
);
   localparam int W  = NCHARS * 8 * (1 << SCALE_LOG2);
   localparam int H  = NLINES * 8 * (1 << SCALE_LOG2);
   localparam int BW = NLINES * NCHARS * 5;
   localparam int IW = $clog2(BW);

   logic [9:0]    rx, ry, cx, cy;
   logic          win0, win1, vis2, pix;
   logic [6:0]    li1, ci1;
   logic [2:0]    row1, col1, row2, col2;
   logic [4:0]    code1, code2;
   logic [IW-1:0] idx;
   logic [5:0]    gi;
   logic [34:0]   glyph;
   logic [23:0]   d1, d2, mixed;
   logic [BW-1:0] disp;

   // Rows top to bottom, each 5 bits with the leftmost pixel in bit 4.
   function automatic logic [34:0] glyph_rom(input logic [4:0] c);
      case (c)
         5'h00: return {5'h0E, 5'h11, 5'h13, 5'h15, 5'h19, 5'h11, 5'h0E};
         5'h01: return {5'h04, 5'h0C, 5'h04, 5'h04, 5'h04, 5'h04, 5'h0E};
         5'h02: return {5'h0E, 5'h11, 5'h01, 5'h02, 5'h04, 5'h08, 5'h1F};
         5'h03: return {5'h1F, 5'h02, 5'h04, 5'h02, 5'h01, 5'h11, 5'h0E};
         5'h04: return {5'h02, 5'h06, 5'h0A, 5'h12, 5'h1F, 5'h02, 5'h02};
         5'h05: return {5'h1F, 5'h10, 5'h1E, 5'h01, 5'h01, 5'h11, 5'h0E};
         5'h06: return {5'h06, 5'h08, 5'h10, 5'h1E, 5'h11, 5'h11, 5'h0E};
         5'h07: return {5'h1F, 5'h01, 5'h02, 5'h04, 5'h08, 5'h08, 5'h08};
         5'h08: return {5'h0E, 5'h11, 5'h11, 5'h0E, 5'h11, 5'h11, 5'h0E};
         5'h09: return {5'h0E, 5'h11, 5'h11, 5'h0F, 5'h01, 5'h02, 5'h0C};
         5'h0A: return {5'h0E, 5'h11, 5'h11, 5'h1F, 5'h11, 5'h11, 5'h11};
         5'h0B: return {5'h1E, 5'h11, 5'h11, 5'h1E, 5'h11, 5'h11, 5'h1E};
         5'h0C: return {5'h0E, 5'h11, 5'h10, 5'h10, 5'h10, 5'h11, 5'h0E};
         5'h0D: return {5'h1C, 5'h12, 5'h11, 5'h11, 5'h11, 5'h12, 5'h1C};
         5'h0E: return {5'h1F, 5'h10, 5'h10, 5'h1E, 5'h10, 5'h10, 5'h1F};
         5'h0F: return {5'h1F, 5'h10, 5'h10, 5'h1E, 5'h10, 5'h10, 5'h10};
         5'h11: return {5'h00, 5'h00, 5'h00, 5'h1F, 5'h00, 5'h00, 5'h00};
         5'h12: return {5'h00, 5'h0C, 5'h0C, 5'h00, 5'h0C, 5'h0C, 5'h00};
         5'h13: return {5'h0E, 5'h11, 5'h10, 5'h17, 5'h11, 5'h11, 5'h0F};
         5'h14: return {5'h11, 5'h11, 5'h11, 5'h1F, 5'h11, 5'h11, 5'h11};
         5'h15: return {5'h0E, 5'h04, 5'h04, 5'h04, 5'h04, 5'h04, 5'h0E};
         5'h16: return {5'h07, 5'h02, 5'h02, 5'h02, 5'h02, 5'h12, 5'h0C};
         5'h17: return {5'h11, 5'h12, 5'h14, 5'h18, 5'h14, 5'h12, 5'h11};
         5'h18: return {5'h10, 5'h10, 5'h10, 5'h10, 5'h10, 5'h10, 5'h1F};
         5'h19: return {5'h11, 5'h1B, 5'h15, 5'h15, 5'h11, 5'h11, 5'h11};
         5'h1A: return {5'h11, 5'h11, 5'h19, 5'h15, 5'h13, 5'h11, 5'h11};
         5'h1B: return {5'h0E, 5'h11, 5'h11, 5'h11, 5'h11, 5'h11, 5'h0E};
         5'h1C: return {5'h1E, 5'h11, 5'h11, 5'h1E, 5'h10, 5'h10, 5'h10};
         5'h1D: return {5'h1E, 5'h11, 5'h11, 5'h1E, 5'h14, 5'h12, 5'h11};
         5'h1E: return {5'h0F, 5'h10, 5'h10, 5'h0E, 5'h01, 5'h01, 5'h1E};
         default: return '0;
      endcase
   endfunction

`ifdef OVERLAY_SHADOW_EN
   logic          vb_q;
   logic [BW-1:0] shadow;
   always_ff @(posedge clk_sys) begin
      if (reset) begin
         vb_q   <= 1'b0;
         shadow <= '1;
      end else begin
         vb_q <= bus.vblank;
         if (bus.vblank && !vb_q) shadow <= bus.line_data;
      end
   end
   assign disp = shadow;
`else
   assign disp = bus.line_data;
`endif

   assign rx    = bus.hcount - 10'(X0);
   assign ry    = bus.vcount - 10'(Y0);
   assign cx    = rx >> SCALE_LOG2;
   assign cy    = ry >> SCALE_LOG2;
   assign win0  = bus.ena && int'(bus.hcount) >= X0 && int'(rx) < W &&
                  int'(bus.vcount) >= Y0 && int'(ry) < H;
   // Char 0 sits in the top 5 bits of its line, so the column index runs backwards.
   assign idx   = IW'((int'(li1) * NCHARS + NCHARS - 1 - int'(ci1)) * 5);
   assign code1 = win1 ? disp[idx +: 5] : 5'h1F;

   always_ff @(posedge clk_sys) begin
      if (reset) begin
         win1  <= 1'b0;
         li1   <= '0;
         ci1   <= '0;
         row1  <= '0;
         col1  <= '0;
         d1    <= '0;
         vis2  <= 1'b0;
         code2 <= '0;
         row2  <= '0;
         col2  <= '0;
         d2    <= '0;
      end else begin
         win1  <= win0;
         li1   <= cy[9:3];
         ci1   <= cx[9:3];
         row1  <= cy[2:0];
         col1  <= cx[2:0];
         d1    <= {bus.in_r, bus.in_g, bus.in_b};
         vis2  <= code1 != 5'h1F;
         code2 <= code1;
         row2  <= row1;
         col2  <= col1;
         d2    <= d1;
      end
   end

   always_comb begin
      glyph = glyph_rom(code2);
      gi    = 6'(34 - 5 * int'(row2) - int'(col2));
      pix   = row2 != 3'd7 && col2 < 3'd5 && glyph[gi];
      mixed = !vis2 ? d2 : pix ? 24'hFFFFFF :
              {1'b0, d2[23:17], 1'b0, d2[15:9], 1'b0, d2[7:1]};
   end

   assign bus.out_r  = mixed[23:16];
   assign bus.out_g  = mixed[15:8];
   assign bus.out_b  = mixed[7:0];
   assign bus.active = vis2;
endmodule

// File: tb/tb_debug_overlay.sv
// tb_debug_overlay: scoreboard bench driving an unscaled 2x32 and a 2x-scaled 1x4 overlay.
module tb_debug_overlay;
   logic clk_sys = 1'b0;
   logic reset = 1'b1;
   always #5 clk_sys = ~clk_sys;

   debug_overlay_if #(.NLINES(2), .NCHARS(32)) ifa ();
   debug_overlay_if #(.NLINES(1), .NCHARS(4))  ifb ();

   debug_overlay #(.NLINES(2), .NCHARS(32), .X0(16), .Y0(8), .SCALE_LOG2(0))
      dut_a (.clk_sys(clk_sys), .reset(reset), .bus(ifa));
   debug_overlay #(.NLINES(1), .NCHARS(4), .X0(16), .Y0(8), .SCALE_LOG2(1))
      dut_b (.clk_sys(clk_sys), .reset(reset), .bus(ifb));

   typedef struct {
      logic [9:0]  h, v;
      logic        ka, kb;
      logic [24:0] a, b;
   } exp_t;

   exp_t         sb[$];
   int           errors = 0;
   int           checks = 0;
   logic         nrst = 1'b1, nvb = 1'b0;
   logic [319:0] nlda;
   logic [19:0]  nldb;
   logic [319:0] sh_a;
   logic [19:0]  sh_b;
   logic         vb_q;
   logic         pv = 1'b0, prst, pen;
   logic [9:0]   ph, pvc;
   logic [23:0]  prgb;

   // Reference frame buffer: what the overlay should be showing this frame.
   always @(posedge clk_sys) begin
      if (reset) begin
         vb_q <= 1'b0;
         sh_a <= '1;
         sh_b <= '1;
      end else begin
         vb_q <= ifa.vblank;
         if (ifa.vblank && !vb_q) begin
            sh_a <= ifa.line_data;
            sh_b <= ifb.line_data;
         end
      end
   end

   task automatic check(input string tag, input logic [24:0] got, input logic [24:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Returns {known, active, rgb}; only glyph '1' row 0, blank space and row 7 / cols 5-7 are predicted.
   function automatic logic [25:0] model(input int sc, input int nc, input int nl, input logic [9:0] h,
                                         input logic [9:0] v, input logic en, input logic [23:0] rgb,
                                         input logic [319:0] buff);
      int rx, ry, cx, cy;
      logic [4:0] c;
      rx = int'(h) - 16;
      ry = int'(v) - 8;
      if (!en || rx < 0 || ry < 0 || rx >= nc * 8 * (1 << sc) || ry >= nl * 8 * (1 << sc))
         return {2'b10, rgb};
      cx = rx >> sc;
      cy = ry >> sc;
      c = 5'(buff >> (((cy / 8) * nc + nc - 1 - cx / 8) * 5));
      if (c == 5'h1F) return {2'b10, rgb};
      if (c == 5'h01 && cy % 8 != 0 && cy % 8 != 7 && cx % 8 < 5) return 26'd0;
      if (c == 5'h01 && cy % 8 == 0 && cx % 8 == 2) return {2'b11, 24'hFFFFFF};
      return {2'b11, 1'b0, rgb[23:17], 1'b0, rgb[15:9], 1'b0, rgb[7:1]};
   endfunction

   task automatic put_a(input int line, input int ch, input logic [4:0] code);
      int sh;
      sh = ((line * 32) + 31 - ch) * 5;
      nlda = (nlda & ~(320'h1F << sh)) | (320'(code) << sh);
   endtask

   task automatic step(input logic [9:0] h, input logic [9:0] v, input logic en, input logic [23:0] rgb);
      exp_t e;
      logic [319:0] ba;
      logic [19:0] bb;
      logic [25:0] ma, mb;
      @(negedge clk_sys);
      if (sb.size() > 0) begin
         e = sb.pop_front();
         if (e.ka) check($sformatf("A h=%0d v=%0d", e.h, e.v),
                         {ifa.active, ifa.out_r, ifa.out_g, ifa.out_b}, e.a);
         if (e.kb) check($sformatf("B h=%0d v=%0d", e.h, e.v),
                         {ifb.active, ifb.out_r, ifb.out_g, ifb.out_b}, e.b);
      end
      reset = nrst;
      ifa.vblank = nvb;    ifb.vblank = nvb;
      ifa.line_data = nlda; ifb.line_data = nldb;
      ifa.hcount = h;      ifb.hcount = h;
      ifa.vcount = v;      ifb.vcount = v;
      ifa.ena = en;        ifb.ena = en;
      {ifa.in_r, ifa.in_g, ifa.in_b} = rgb;
      {ifb.in_r, ifb.in_g, ifb.in_b} = rgb;
      if (pv) begin
`ifdef OVERLAY_SHADOW_EN
         ba = sh_a;
         bb = sh_b;
`else
         ba = nlda;
         bb = nldb;
`endif
         if (prst || nrst) begin
            e.ka = 1'b1; e.kb = 1'b1; e.a = '0; e.b = '0;
         end else begin
            ma = model(0, 32, 2, ph, pvc, pen, prgb, ba);
            mb = model(1, 4, 1, ph, pvc, pen, prgb, 320'(bb));
            e.ka = ma[25]; e.a = ma[24:0];
            e.kb = mb[25]; e.b = mb[24:0];
         end
         e.h = ph;
         e.v = pvc;
         sb.push_back(e);
      end
      pv = 1'b1; prst = nrst; ph = h; pvc = v; pen = en; prgb = rgb;
   endtask

   task automatic scan(input logic [9:0] v, input int h0, input int h1, input logic en,
                       input logic [23:0] rgb, input logic rnd);
      for (int h = h0; h <= h1; h++) step(10'(h), v, en, rnd ? 24'($urandom) : rgb);
   endtask

   task automatic vblank_pulse();
      nvb = 1'b1;
      repeat (2) step(10'd0, 10'd300, 1'b1, 24'h0);
      nvb = 1'b0;
      step(10'd0, 10'd0, 1'b1, 24'h0);
   endtask

   initial begin
      nlda = '0;
      for (int l = 0; l < 2; l++)
         for (int c = 0; c < 32; c++) put_a(l, c, 5'h10);
      put_a(0, 0, 5'h01);
      put_a(0, 1, 5'h1F);
      put_a(0, 5, 5'h01);
      put_a(1, 0, 5'h01);
      put_a(1, 31, 5'h1F);
      nldb = {5'h01, 5'h1F, 5'h10, 5'h01};
      repeat (4) step(10'd20, 10'd8, 1'b1, 24'h123456);
      nrst = 1'b0;
      scan(10'd8, 14, 30, 1'b0, 24'h123456, 1'b0);
      scan(10'd8, 14, 30, 1'b1, 24'h0, 1'b1);
      vblank_pulse();
      scan(10'd8, 14, 24, 1'b1, 24'h808080, 1'b0);
      scan(10'd7, 14, 40, 1'b1, 24'h0, 1'b1);
      scan(10'd9, 14, 40, 1'b1, 24'h0, 1'b1);
      scan(10'd15, 14, 60, 1'b1, 24'h0, 1'b1);
      scan(10'd16, 14, 30, 1'b1, 24'h0, 1'b1);
      scan(10'd23, 14, 30, 1'b1, 24'h0, 1'b1);
      scan(10'd24, 14, 30, 1'b1, 24'h0, 1'b1);
      scan(10'd8, 76, 84, 1'b1, 24'h0, 1'b1);
      scan(10'd8, 266, 276, 1'b1, 24'h0, 1'b1);
      for (int i = 0; i < 24; i++) begin
         if (i == 10) begin
            put_a(0, 0, 5'h10);
            nldb = {5'h10, 5'h1F, 5'h10, 5'h01};
         end
         step(10'(16 + i % 8), 10'd8, 1'b1, 24'($urandom));
      end
      vblank_pulse();
      scan(10'd8, 14, 24, 1'b1, 24'h0, 1'b1);
      for (int h = 14; h <= 40; h++) step(10'(h), 10'd8, h < 25, 24'($urandom));
      put_a(0, 0, 5'h01);
      nldb = {5'h01, 5'h1F, 5'h10, 5'h01};
      scan(10'd8, 14, 18, 1'b1, 24'h0, 1'b1);
      nrst = 1'b1;
      scan(10'd8, 19, 23, 1'b1, 24'hFFFFFF, 1'b0);
      nrst = 1'b0;
      scan(10'd8, 14, 30, 1'b1, 24'h0, 1'b1);
      vblank_pulse();
      scan(10'd8, 14, 30, 1'b1, 24'h0, 1'b1);
      repeat (3) step(10'd0, 10'd0, 1'b0, 24'h0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
